// File: rtl/conv_drain_pkg.sv
// -----------------------------------------------------------------------------
// conv_drain_pkg
// Shared types and constants for the convolution result drain:
//   - state_e     : drain FSM states
//   - FIFO_DEPTH  : depth of the output FIFO that hides the MEMZ read latency
//   - COUNT_W     : width of the FIFO occupancy count
//   - drain_len() : number of result words for a given (sizeX, sizeY)
// -----------------------------------------------------------------------------
package conv_drain_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 5;

    localparam int FIFO_DEPTH = 2;
    localparam int COUNT_W    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Full-convolution output length; an empty operand yields an empty result.
    // Callers truncate to ADDR_WIDTH+1 bits, which always holds the maximum.
    function automatic int unsigned drain_len(input int unsigned size_x,
                                              input int unsigned size_y);
        if (size_x == 0 || size_y == 0) begin
            return 0;
        end
        return size_x + size_y - 1;
    endfunction

endpackage

// File: rtl/conv_result_drain_if.sv
// -----------------------------------------------------------------------------
// conv_result_drain_if
// Bundles the MEMZ read port and the valid/ready result stream.
//   memZ_addr / memZ_rd : read request toward MEMZ (data returns 1 cycle later)
//   dataZ_in            : MEMZ read data
//   out_data / out_valid / out_last / out_ready : result stream to the host
// Modports: master = drain block, slave = MEMZ + stream consumer.
// -----------------------------------------------------------------------------
interface conv_result_drain_if
    import conv_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [ADDR_WIDTH:0]       memZ_addr;
    logic                      memZ_rd;
    logic [2*DATA_WIDTH-1:0]   dataZ_in;
    logic [2*DATA_WIDTH-1:0]   out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;

    modport master (
        output memZ_addr, memZ_rd, out_data, out_valid, out_last,
        input  dataZ_in, out_ready
    );

    modport slave (
        input  memZ_addr, memZ_rd, out_data, out_valid, out_last,
        output dataZ_in, out_ready
    );
endinterface

// File: rtl/drain_fifo2.sv
// -----------------------------------------------------------------------------
// drain_fifo2
// Two-entry synchronous FIFO. The head entry is a dedicated register so dout
// only changes on a pop (or on the first push into an empty FIFO).
//   clk, rstn : clock, asynchronous active-low clear
//   flush     : synchronous clear of the occupancy
//   push/din  : write port (caller guarantees no push while full unless popping)
//   pop       : read port (ignored while empty)
//   dout      : head entry
//   count     : occupancy 0..2
// -----------------------------------------------------------------------------
module drain_fifo2
    import conv_drain_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic [COUNT_W-1:0] count
);
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop_ok;

    assign pop_ok = pop && (count != '0);
    assign dout   = head;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the storage is reset too, because the head drives out_data and
    // that output has a defined reset value of zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case ({push, pop_ok})
                2'b10: begin
                    if (count == '0) head <= din;
                    else             tail <= din;
                    count <= count + COUNT_W'(1);
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - COUNT_W'(1);
                end
                2'b11: begin
                    // Occupancy unchanged; with one entry the new word
                    // replaces the leaving head directly.
                    if (count == COUNT_W'(1)) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/conv_result_drain.sv
// -----------------------------------------------------------------------------
// conv_result_drain
// Reads MEMZ addresses 0..len-1 after the core finishes and streams each
// 2*DATA_WIDTH result word out on a valid/ready port. A 2-entry FIFO plus a
// credit check on reads keeps one word per cycle flowing despite the
// one-cycle MEMZ read latency.
//   clk, rstn : clock, asynchronous active-low reset
//   start     : one-cycle pulse that begins a drain (accepted only in IDLE)
//   config_in : {sizeY, sizeX}, sampled on an accepted start
//   busy_out  : high from the cycle after start through the done_out cycle
//   done_out  : one-cycle pulse after the final transfer
//   bus       : MEMZ read port and result stream (master side)
// -----------------------------------------------------------------------------
module conv_result_drain
    import conv_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [2*ADDR_WIDTH-1:0] config_in,
    output logic                    busy_out,
    output logic                    done_out,
    conv_result_drain_if.master     bus
);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int WORD_W = 2 * DATA_WIDTH;

    state_e             state;
    logic [LEN_W-1:0]   cfg_len;
    logic [LEN_W-1:0]   rd_cnt;
    logic [LEN_W-1:0]   tx_cnt;
    logic               inflight;     // read issued last cycle, data lands now
    logic [LEN_W-1:0]   start_len;
    logic               accept;
    logic               pop;
    logic               issue;
    logic [2:0]         occ_next;
    logic [COUNT_W-1:0] fifo_count;
    logic [WORD_W-1:0]  fifo_dout;

    assign start_len = LEN_W'(drain_len(32'(config_in[ADDR_WIDTH-1:0]),
                                        32'(config_in[2*ADDR_WIDTH-1:ADDR_WIDTH])));
    assign accept    = (state == IDLE) && start;

    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_data  = fifo_dout;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_last  = bus.out_valid && (tx_cnt == cfg_len - LEN_W'(1));

    // Occupancy the FIFO will have after this edge, counting the word still in
    // flight from MEMZ. A new read is safe only if that leaves room for it.
    assign occ_next = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue    = (state == RUN) && (rd_cnt < cfg_len) && (occ_next <= 3'd1);

    assign bus.memZ_rd   = issue;
    assign bus.memZ_addr = rd_cnt;

    drain_fifo2 #(
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (accept),
        .push  (inflight),
        .pop   (pop),
        .din   (bus.dataZ_in),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cfg_len  <= '0;
            rd_cnt   <= '0;
            tx_cnt   <= '0;
            inflight <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            inflight <= issue;
            done_out <= 1'b0;
            if (issue) rd_cnt <= rd_cnt + LEN_W'(1);
            if (pop)   tx_cnt <= tx_cnt + LEN_W'(1);

            unique case (state)
                IDLE: begin
                    if (start) begin
                        cfg_len  <= start_len;
                        rd_cnt   <= '0;
                        tx_cnt   <= '0;
                        busy_out <= 1'b1;
                        if (start_len == '0) begin
                            state    <= DONE;
                            done_out <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue && (rd_cnt + LEN_W'(1) == cfg_len)) state <= FLUSH;
                end
                FLUSH: begin
                    // Finish on the edge of the last transfer so done_out
                    // lands in the very next cycle.
                    if (!inflight && (fifo_count == COUNT_W'(pop))) begin
                        state    <= DONE;
                        done_out <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_result_drain.sv
// -----------------------------------------------------------------------------
// tb_conv_result_drain
// Directed bench for conv_result_drain. A MEMZ model answers reads one cycle
// later with mem_base + address; a reference model expects the stream to be
// mem_base + 0 .. mem_base + len - 1 in order, with out_last on word len-1,
// and checks read addresses, read credit and stall stability every cycle.
// -----------------------------------------------------------------------------
module tb_conv_result_drain;
    import conv_drain_pkg::*;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [2*AW-1:0] config_in = '0;
    logic          busy_out;
    logic          done_out;

    conv_result_drain_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    conv_result_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .config_in (config_in),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    // ---------------- MEMZ model ----------------
    logic [15:0] memz [64];
    int          mem_base = 'h100;

    task automatic fill_mem();
        for (int a = 0; a < 64; a++) memz[a] = 16'(mem_base + a);
    endtask

    always @(posedge clk) begin
        if (bus.memZ_rd) bus.dataZ_in <= memz[bus.memZ_addr];
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int exp_base, exp_len;
    int n_xfer, n_rd, n_valid, done_cnt, done_cyc;
    int first_xfer_cyc, last_xfer_cyc, first_rd_cyc, last_addr, last_cnt, last_idx;
    logic [15:0] first_word, last_word, prev_data;
    bit prev_stall, prev_last;
    logic [3:0] pat = 4'b1001;   // out_ready sequence 1,0,0,1 (bit i)

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        n_xfer = 0; n_rd = 0; n_valid = 0; done_cnt = 0; done_cyc = -1;
        first_xfer_cyc = -1; last_xfer_cyc = -1; first_rd_cyc = -1;
        last_addr = -1; last_cnt = 0; last_idx = -1;
        first_word = '0; last_word = '0; prev_stall = 1'b0; prev_last = 1'b0;
        prev_data = '0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: outputs are sampled mid-cycle, i.e. what the next
    // rising edge will see.
    always @(negedge clk) begin
        if (chk_en && rstn) begin
            bit pop;
            pop = bus.out_valid && bus.out_ready;
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'(1));
                check("stall_data", 32'(bus.out_data), 32'(prev_data));
                check("stall_last", 32'(bus.out_last), 32'(prev_last));
            end
            if (bus.out_valid) begin
                n_valid++;
                check("data", 32'(bus.out_data), 32'(16'(exp_base + n_xfer)));
                check("last_flag", 32'(bus.out_last), 32'(n_xfer == exp_len - 1));
                check("word_in_range", 32'(n_xfer < exp_len), 32'(1));
            end else begin
                check("last_no_valid", 32'(bus.out_last), 32'(0));
            end
            if (bus.memZ_rd) begin
                if (n_rd == 0) first_rd_cyc = cyc;
                check("rd_addr", 32'(bus.memZ_addr), 32'(n_rd));
                check("rd_credit", 32'((n_rd - n_xfer - int'(pop) + 1) <= 2), 32'(1));
                check("rd_in_range", 32'(n_rd < exp_len), 32'(1));
                last_addr = int'(bus.memZ_addr);
                n_rd++;
            end
            if (pop) begin
                if (n_xfer == 0) begin
                    first_xfer_cyc = cyc;
                    first_word = bus.out_data;
                end
                last_xfer_cyc = cyc;
                last_word = bus.out_data;
                if (bus.out_last) begin
                    last_cnt++;
                    last_idx = n_xfer;
                end
                n_xfer++;
            end
            if (done_out) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(bus.memZ_addr), 32'(0));
        check({tag, "_rd"},    32'(bus.memZ_rd),   32'(0));
        check({tag, "_data"},  32'(bus.out_data),  32'(0));
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(0));
        check({tag, "_last"},  32'(bus.out_last),  32'(0));
        check({tag, "_busy"},  32'(busy_out),      32'(0));
        check({tag, "_done"},  32'(done_out),      32'(0));
    endtask

    // Pulse start, then run until done_out or the cycle budget expires.
    task automatic run_drain(input int sx, input int sy, input bit stall,
                             input int budget, input int restart_at,
                             output int start_cyc);
        exp_base = mem_base;
        exp_len  = (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
        fill_mem();
        reset_model();
        chk_en = 1'b1;
        @(posedge clk); #1;
        config_in = {5'(sy), 5'(sx)};
        start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;              // E0 has just happened
        start = 1'b0;
        config_in = {5'd2, 5'd2};        // must not affect the running drain
        start_cyc = cyc;
        check("busy_after_start", 32'(busy_out), 32'(1));
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            bus.out_ready = stall ? pat[i % 4] : 1'b1;
            start = (i == restart_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
        check("done_seen", 32'(done_cnt), 32'(1));
        check("busy_cleared", 32'(busy_out), 32'(0));
        check("done_single", 32'(done_out), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        bus.out_ready = 1'b0;
        bus.dataZ_in  = '0;
        fill_mem();
        reset_model();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        // 1) 4x3 -> 6 words, out_ready held high
        mem_base = 'h100;
        run_drain(4, 3, 1'b0, 40, -1, sc);
        check("t1_n_xfer", 32'(n_xfer), 32'(6));
        check("t1_first_rd", 32'(first_rd_cyc), 32'(sc));
        check("t1_first_xfer", 32'(first_xfer_cyc), 32'(sc + 2));
        check("t1_last_xfer", 32'(last_xfer_cyc), 32'(sc + 7));
        check("t1_done_cyc", 32'(done_cyc), 32'(sc + 8));
        check("t1_first_word", 32'(first_word), 32'h100);
        check("t1_last_word", 32'(last_word), 32'h105);
        check("t1_last_addr", 32'(last_addr), 32'(5));
        check("t1_last_cnt", 32'(last_cnt), 32'(1));
        check("t1_last_idx", 32'(last_idx), 32'(5));

        // 2) same config, out_ready 1,0,0,1,...
        run_drain(4, 3, 1'b1, 80, -1, sc);
        check("t2_n_xfer", 32'(n_xfer), 32'(6));
        check("t2_last_word", 32'(last_word), 32'h105);
        check("t2_last_cnt", 32'(last_cnt), 32'(1));

        // 3) sizeX = 0 -> empty drain
        run_drain(0, 7, 1'b0, 10, -1, sc);
        check("t3_done_cyc", 32'(done_cyc), 32'(sc));
        check("t3_n_rd", 32'(n_rd), 32'(0));
        check("t3_n_valid", 32'(n_valid), 32'(0));

        // 4) 31x31 -> 61 words, stray start mid-drain
        run_drain(31, 31, 1'b0, 200, 10, sc);
        check("t4_n_xfer", 32'(n_xfer), 32'(61));
        check("t4_last_addr", 32'(last_addr), 32'(60));
        check("t4_last_word", 32'(last_word), 32'h13C);
        check("t4_last_cnt", 32'(last_cnt), 32'(1));
        check("t4_last_idx", 32'(last_idx), 32'(60));

        // 5) reset after the 3rd transfer of a 6-word drain
        exp_base = mem_base;
        exp_len  = 6;
        reset_model();
        chk_en = 1'b1;
        @(posedge clk); #1;
        config_in = {5'd3, 5'd4};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && n_xfer < 3; i++) begin
            @(posedge clk); #1;
        end
        check("t5_three_xfers", 32'(n_xfer), 32'(3));
        #2;
        chk_en = 1'b0;
        rstn = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("t5_held");
        rstn = 1'b1;
        @(negedge clk);
        check("t5_no_done", 32'(done_out), 32'(0));
        check("t5_no_valid", 32'(bus.out_valid), 32'(0));

        mem_base = 'h200;
        run_drain(4, 3, 1'b0, 40, -1, sc);
        check("t5_n_xfer", 32'(n_xfer), 32'(6));
        check("t5_first_word", 32'(first_word), 32'h200);
        check("t5_last_word", 32'(last_word), 32'h205);
        check("t5_first_xfer", 32'(first_xfer_cyc), 32'(sc + 2));

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
